countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Loadable down-counting timer: counts a programmed value down to zero and signals expiry, in one-shot or periodic (auto-reload) mode. Complements the up/down event counter: that block accumulates occurrences; this block consumes a programmed interval. Used for timeouts, watchdogs and periodic ticks in peripheral and cache-controller logic.

Parameters:
WIDTH, 16, bit width of the load value and counter (>= 1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous clear; highest priority
start_i  input  1  load load_val_i and (re)start counting
stop_i  input  1  pause; counter holds value
periodic_i  input  1  sampled with start_i: 1 = auto-reload, 0 = one-shot
load_val_i  input  WIDTH  interval value sampled with start_i
count_o  output  WIDTH  current counter value (registered)
busy_o  output  1  high while in RUN
expired_o  output  1  expiry indication (registered)

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset: count_o=0, busy_o=0, expired_o=0, state IDLE, reload register 0, periodic flag 0.
- Internal state: IDLE, RUN; reload register (WIDTH); periodic flag.
- Per-cycle priority: clear_i > start_i > stop_i > RUN countdown.
- clear_i: count<=0, reload<=0, periodic<=0, state<=IDLE, expired_o<=0.
- start_i, any state: count<=load_val_i, reload<=load_val_i, periodic<=periodic_i, state<=RUN, expired_o<=0. A start coinciding with an expiry suppresses that expiry.
- stop_i, RUN: state<=IDLE, count holds, no expiry. stop_i in IDLE: no effect. Restart only via start_i; there is no resume.
- RUN, count!=0: count<=count-1.
- RUN, count==0: expired_o asserted for the next cycle. If periodic and reload!=0: count<=reload, stay in RUN. Otherwise: state<=IDLE, count stays 0.
- Periodic with load value 0 behaves as one-shot, so the timer cannot expire on every cycle.
- Timing: start_i at edge T with value N gives count_o=N after T, 0 after T+N, and expired_o high for the cycle after edge T+N+1. Periodic period is N+1 cycles.
- No wrap-around: the counter never decrements below 0.
- IDLE: count_o holds. expired_o deasserts the cycle after a pulse (non-sticky build).
- busy_o = (state==RUN), registered.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous).

Optional Feature:
Macro COUNTDOWN_TIMER_STICKY_EN.
- Defined: expired_o is sticky. Once set it stays high until clear_i or start_i. In periodic mode, further expiries keep it high. Intended as a level interrupt source.
- Undefined: expired_o is a one-cycle pulse per expiry.
- Ports are identical in both builds.

Test Plan:
- Reset release, no stimulus -> count_o=0, busy_o=0, expired_o=0 for 10 cycles.
- start_i with load_val_i=5, periodic_i=0 -> count_o 5,4,3,2,1,0; expired_o high exactly one cycle after 0 is reached; busy_o falls with expiry; count_o stays 0.
- start_i with load_val_i=3, periodic_i=1, run 20 cycles -> expired_o pulses every 4 cycles; count_o sequence 3,2,1,0,3,2,...
- start_i with 10; stop_i when count_o=6 -> busy_o=0, count_o holds 6, no expiry. Later start_i with 2 -> restarts from 2.
- Collisions: start_i with 4 in the cycle count_o==0 -> no expiry pulse, count_o=4. clear_i together with start_i -> count_o=0, IDLE. load_val_i=0 with periodic_i=1 -> single expiry, then IDLE.
- Sticky build, periodic with 2 -> expired_o rises after first expiry and stays high until clear_i. Non-sticky build, same stimulus -> single-cycle pulses.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: the controlling agent drives commands and load value.
// slave : the timer consumes commands and reports count/busy/expired.
interface countdown_timer_if #(
  parameter int WIDTH = 16
);
  logic             clear_i;
  logic             start_i;
  logic             stop_i;
  logic             periodic_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             expired_o;

  modport master (
    output clear_i, start_i, stop_i, periodic_i, load_val_i,
    input  count_o, busy_o, expired_o
  );

  modport slave (
    input  clear_i, start_i, stop_i, periodic_i, load_val_i,
    output count_o, busy_o, expired_o
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes.
// Command priority each cycle: clear > start > stop > countdown.
// Optional build macro COUNTDOWN_TIMER_STICKY_EN: when defined, expired_o is a
// sticky level cleared only by clear_i or start_i; otherwise it is a one-cycle
// pulse per expiry. Ports are identical in both builds.
module countdown_timer #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  countdown_timer_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] reload_q,   reload_d;
  logic             periodic_q, periodic_d;
  logic             expired_q,  expired_d;
  logic             busy_q,     busy_d;

  // Expiry event of the current cycle, before sticky/pulse shaping.
  logic             expire_evt;

  // Next-state and output computation for the IDLE/RUN controller.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    expire_evt = 1'b0;
`ifdef COUNTDOWN_TIMER_STICKY_EN
    expired_d  = expired_q;
`else
    expired_d  = 1'b0;
`endif

    if (bus.clear_i) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      reload_d   = '0;
      periodic_d = 1'b0;
      expired_d  = 1'b0;
    end else if (bus.start_i) begin
      // A start landing on the expiry cycle wins and suppresses that expiry.
      state_d    = ST_RUN;
      count_d    = bus.load_val_i;
      reload_d   = bus.load_val_i;
      periodic_d = bus.periodic_i;
      expired_d  = 1'b0;
    end else if (bus.stop_i && state_q == ST_RUN) begin
      // Pause: the count is frozen; restart only through start_i.
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expire_evt = 1'b1;
        // A zero reload would expire every cycle, so it falls back to one-shot.
        if (periodic_q && reload_q != '0) begin
          count_d = reload_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end

    if (expire_evt) begin
      expired_d = 1'b1;
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers; all return to zero/IDLE on asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.count_o   = count_q;
  assign bus.busy_o    = busy_q;
  assign bus.expired_o = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer. Each driven cycle pushes the
// expected post-edge outputs onto a scoreboard queue; the entry is popped and
// compared once the DUT has updated. Follows COUNTDOWN_TIMER_STICKY_EN if set.
module tb_countdown_timer;

  localparam int W = 8;

  typedef struct {
    string        tag;
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
  } exp_t;

  logic clk;
  logic rst_n;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  // Reference model state.
  int   m_cnt;
  int   m_rel;
  bit   m_per;
  bit   m_run;
  bit   m_exp;
  int   pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_per = 1'b0; m_run = 1'b0; m_exp = 1'b0;
  endtask

  // Reference behaviour of one clock edge given the inputs applied before it.
  task automatic model_step(input bit clr, input bit st, input bit sp,
                            input bit per, input int val);
    bit fire;
    fire = 1'b0;
    if (clr) begin
      model_reset();
    end else if (st) begin
      m_cnt = val; m_rel = val; m_per = per; m_run = 1'b1; m_exp = 1'b0;
    end else begin
      if (m_run && sp) begin
        m_run = 1'b0;
      end else if (m_run) begin
        if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end else begin
          fire = 1'b1;
          if (!(m_per && m_rel > 0)) m_run = 1'b0;
          else m_cnt = m_rel;
        end
      end
`ifdef COUNTDOWN_TIMER_STICKY_EN
      m_exp = m_exp | fire;
`else
      m_exp = fire;
`endif
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic cycle(input string tag, input bit clr, input bit st, input bit sp,
                       input bit per, input int val);
    exp_t e;
    @(negedge clk);
    bus.clear_i    = clr;
    bus.start_i    = st;
    bus.stop_i     = sp;
    bus.periodic_i = per;
    bus.load_val_i = W'(val);
    model_step(clr, st, sp, per, val);
    e.tag = tag; e.count = W'(m_cnt); e.busy = m_run; e.expired = m_exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".count"},   32'(bus.count_o),   32'(e.count));
    check({e.tag, ".busy"},    32'(bus.busy_o),    32'(e.busy));
    check({e.tag, ".expired"}, 32'(bus.expired_o), 32'(e.expired));
    if (bus.expired_o === 1'b1) pulses++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    checks = 0; errors = 0; pulses = 0;
    model_reset();
    bus.clear_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
    bus.periodic_i = 1'b0; bus.load_val_i = '0;
    rst_n = 1'b0;
    #12;
    check("rst.count",   32'(bus.count_o),   32'd0);
    check("rst.busy",    32'(bus.busy_o),    32'd0);
    check("rst.expired", 32'(bus.expired_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset release.
    idle("quiet", 10);

    // One-shot of 5: 5,4,3,2,1,0 then a single expiry and IDLE at 0.
    cycle("os_start", 1'b0, 1'b1, 1'b0, 1'b0, 5);
    check("os_load", 32'(bus.count_o), 32'd5);
    pulses = 0;
    idle("os_run", 9);
    check("os_pulses", 32'(pulses), 32'd1);
    check("os_final", 32'(bus.count_o), 32'd0);

    // Periodic of 3 over 20 cycles: period 4.
    cycle("per_start", 1'b0, 1'b1, 1'b0, 1'b1, 3);
    pulses = 0;
    idle("per_run", 20);
`ifdef COUNTDOWN_TIMER_STICKY_EN
    check("per_level", 32'(bus.expired_o), 32'd1);
`else
    check("per_pulses", 32'(pulses), 32'd5);
`endif
    cycle("per_clear", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Stop at count 6 freezes the count without expiry; restart from 2.
    cycle("stp_start", 1'b0, 1'b1, 1'b0, 1'b0, 10);
    for (int i = 0; i < 20 && bus.count_o !== W'(6); i++) idle("stp_run", 1);
    check("stp_reach6", 32'(bus.count_o), 32'd6);
    cycle("stp_stop", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    pulses = 0;
    idle("stp_hold", 5);
    check("stp_held", 32'(bus.count_o), 32'd6);
    check("stp_noexp", 32'(pulses), 32'd0);
    cycle("stp_stop_idle", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle("stp_restart", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    check("stp_from2", 32'(bus.count_o), 32'd2);
    idle("stp_run2", 4);

    // Start with 4 on the cycle count_o==0 suppresses the expiry.
    cycle("col_start", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    idle("col_run", 2);
    check("col_at0", 32'(bus.count_o), 32'd0);
    cycle("col_restart", 1'b0, 1'b1, 1'b0, 1'b0, 4);
    check("col_noexp", 32'(bus.expired_o), 32'd0);
    check("col_cnt4", 32'(bus.count_o), 32'd4);

    // Clear together with start wins: count 0, IDLE.
    cycle("col_clr_start", 1'b1, 1'b1, 1'b0, 1'b1, 7);
    check("clr_busy", 32'(bus.busy_o), 32'd0);
    idle("clr_idle", 3);

    // Periodic with 0 behaves as one-shot: single expiry.
    cycle("z_start", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    pulses = 0;
    idle("z_run", 6);
    check("z_pulses", 32'(pulses), 32'd1);
    check("z_busy", 32'(bus.busy_o), 32'd0);

    // Periodic with 2: sticky level vs. pulses, then clear.
    cycle("stk_start", 1'b0, 1'b1, 1'b0, 1'b1, 2);
    idle("stk_run", 10);
    cycle("stk_clear", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("stk_cleared", 32'(bus.expired_o), 32'd0);

    // Asynchronous reset mid-count.
    cycle("ar_start", 1'b0, 1'b1, 1'b0, 1'b0, 9);
    idle("ar_run", 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("ar.count", 32'(bus.count_o), 32'd0);
    check("ar.busy",  32'(bus.busy_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("ar_after", 3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
